fetch: RTL and testbench

Instruction fetch stage directly upstream of `memory`. It holds the program counter, issues word reads to the instruction memory port (`addr_i`/`read_en_i`/`data_o` of `memory`), and buffers returned words in a 2-entry queue. It presents them to decode with a valid/ready handshake and accepts a single-cycle redirect (branch/jump) that flushes all fetched and in-flight words.

---
 rtl/fetch.sv | 106 ++++++++++
 tb/tb_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch: PC, one-cycle memory read issue, 2-entry {insn, pc} queue to decode.
// Define FETCH_PERF_EN to add insn_count_o / stall_count_o performance counters.
module fetch #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h01000000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic              mem_read_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] insn_pc_o,
    output logic              insn_valid_o,
    input  logic              insn_ready_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       insn_count_o,
    output logic [31:0]       stall_count_o
`endif
);

    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] req_pc;
    logic              inflight;
    logic              kill;
    logic [1:0]        count;
    logic [DWIDTH-1:0] q_insn [2];
    logic [AWIDTH-1:0] q_pc   [2];

    logic              pop;
    logic              issue;
    logic              capture;
    logic              wr_idx;
    logic [AWIDTH-1:0] redirect_target;

    assign redirect_target = redirect_pc_i & ~AWIDTH'(3);

    assign insn_valid_o = (count != 2'd0) && !redirect_i;
    assign pop          = insn_valid_o && insn_ready_i;
    // Room check counts the word already in flight; the pop term makes issue react to ready combinationally.
    assign issue        = rst && !redirect_i &&
                          (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    assign capture      = inflight && !kill && !redirect_i;
    // Tail slot after this cycle's pop: LSB of (count - pop), since count never exceeds 2.
    assign wr_idx       = count[0] ^ pop;

    assign mem_addr_o    = pc;
    assign mem_read_en_o = issue;
    assign insn_o        = q_insn[0];
    assign insn_pc_o     = q_pc[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= BASE_ADDR;
            req_pc    <= '0;
            inflight  <= 1'b0;
            kill      <= 1'b0;
            count     <= 2'd0;
            q_insn[0] <= '0;
            q_insn[1] <= '0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
        end else if (redirect_i) begin
            pc       <= redirect_target;
            count    <= 2'd0;
            kill     <= inflight;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            // The stale response lands in the redirect cycle itself, so kill never outlives the next cycle.
            kill     <= 1'b0;
            if (issue) begin
                pc     <= pc + AWIDTH'(4);
                req_pc <= pc;
            end
            if (pop) begin
                q_insn[0] <= q_insn[1];
                q_pc[0]   <= q_pc[1];
            end
            if (capture) begin
                q_insn[wr_idx] <= mem_data_i;
                q_pc[wr_idx]   <= req_pc;
            end
            count <= count + {1'b0, capture} - {1'b0, pop};
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            insn_count_o  <= 32'd0;
            stall_count_o <= 32'd0;
        end else begin
            if (pop)
                insn_count_o <= insn_count_o + 32'd1;
            if (insn_valid_o && !insn_ready_i)
                stall_count_o <= stall_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed cycle tables plus a randomized run against a stream-order model.
module tb_fetch;

    localparam logic [31:0] BASE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic [31:0] mem_data = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] insn_count;
    logic [31:0] stall_count;
`endif

    int tests = 0;
    int fails = 0;

    fetch #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr_o    (mem_addr),
        .mem_read_en_o (mem_read_en),
        .mem_data_i    (mem_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .insn_o        (insn),
        .insn_pc_o     (insn_pc),
        .insn_valid_o  (insn_valid),
        .insn_ready_i  (insn_ready)
`ifdef FETCH_PERF_EN
        ,
        .insn_count_o  (insn_count),
        .stall_count_o (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h01000000: return 32'hDEADBEEF;
            32'h01000004: return 32'hA5A5A5A5;
            32'h01000008: return 32'h5A5A5A5A;
            32'h01000100: return 32'h00000013;
            default:      return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Instruction memory with a one-cycle registered read.
    always @(posedge clk)
        if (mem_read_en) mem_data <= mem_word(mem_addr);

    typedef struct {
        logic        rst_v;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        chk_insn;
        logic [31:0] exp_insn;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkvec(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                                   input logic v, input logic en, input logic [31:0] addr,
                                   input logic chk, input logic [31:0] ins, input logic [31:0] pc);
        vec_t t;
        t.rst_v = r; t.ready = rdy; t.redir = rd; t.rpc = rpc;
        t.exp_valid = v; t.exp_en = en; t.exp_addr = addr;
        t.chk_insn = chk; t.exp_insn = ins; t.exp_pc = pc;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, outputs are sampled 1ns later.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst         = v.rst_v;
        insn_ready  = v.ready;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        #1;
    endtask

    task automatic runVectors(input string tag);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s[%0d] valid", tag, i), {31'd0, insn_valid}, {31'd0, vecs[i].exp_valid});
            checkOutput($sformatf("%s[%0d] read_en", tag, i), {31'd0, mem_read_en}, {31'd0, vecs[i].exp_en});
            checkOutput($sformatf("%s[%0d] addr", tag, i), mem_addr, vecs[i].exp_addr);
            if (vecs[i].chk_insn) begin
                checkOutput($sformatf("%s[%0d] insn", tag, i), insn, vecs[i].exp_insn);
                checkOutput($sformatf("%s[%0d] insn_pc", tag, i), insn_pc, vecs[i].exp_pc);
            end
        end
    endtask

    task automatic doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(mkvec(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, BASE, 1'b0, 32'd0, 32'd0));
    endtask

    task automatic addStartRows(input logic rdy2);
        vecs.push_back(mkvec(1, 1, 0, 0, 0, 1, BASE,      1, 32'd0, 32'd0));
        vecs.push_back(mkvec(1, 1, 0, 0, 0, 1, BASE + 4,  1, 32'd0, 32'd0));
        if (rdy2)
            vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 8, 1, 32'hDEADBEEF, BASE));
    endtask

    task automatic addScenario1();
        addStartRows(1'b1);
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 12, 1, 32'hA5A5A5A5, BASE + 4));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 16, 1, 32'h5A5A5A5A, BASE + 8));
    endtask

    task automatic addBackpressure(input int n);
        addStartRows(1'b0);
        for (int i = 0; i < n; i++)
            vecs.push_back(mkvec(1, 0, 0, 0, 1, 0, BASE + 8, 1, 32'hDEADBEEF, BASE));
    endtask

    logic [31:0] exp_issue, exp_pop, prev_insn, prev_pc, r;
    logic        prev_hold;
    int          outstanding, gap, max_gap;
    int unsigned model_pops, model_stalls;

    initial begin
        // Reset release with decode always ready.
        doReset();
        vecs.delete(); addScenario1(); runVectors("start");

        // Five cycles of backpressure, then drain in order.
        doReset();
        vecs.delete(); addBackpressure(5);
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 8,  1, 32'hDEADBEEF, BASE));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 12, 1, 32'hA5A5A5A5, BASE + 4));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 16, 1, 32'h5A5A5A5A, BASE + 8));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, BASE + 20, 1, mem_word(BASE + 12), BASE + 12));
        runVectors("bp");
`ifdef FETCH_PERF_EN
        checkOutput("bp stall_count", stall_count, 32'd5);
        checkOutput("bp insn_count", insn_count, 32'd3);
`endif

        // Redirect to a misaligned target in cycle 3.
        doReset();
        vecs.delete(); addStartRows(1'b1);
        vecs.push_back(mkvec(1, 1, 1, 32'h01000102, 0, 0, BASE + 12, 0, 0, 0));
        vecs.push_back(mkvec(1, 1, 0, 0, 0, 1, 32'h01000100, 0, 0, 0));
        vecs.push_back(mkvec(1, 1, 0, 0, 0, 1, 32'h01000104, 0, 0, 0));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, 32'h01000108, 1, 32'h00000013, 32'h01000100));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, 32'h0100010C, 1, mem_word(32'h01000104), 32'h01000104));
        runVectors("redir");

        // Redirect coinciding with ready while the queue is full.
        doReset();
        vecs.delete(); addBackpressure(5);
        vecs.push_back(mkvec(1, 1, 1, 32'h01000100, 0, 0, BASE + 8, 0, 0, 0));
        vecs.push_back(mkvec(1, 1, 0, 0, 0, 1, 32'h01000100, 0, 0, 0));
        vecs.push_back(mkvec(1, 1, 0, 0, 0, 1, 32'h01000104, 0, 0, 0));
        vecs.push_back(mkvec(1, 1, 0, 0, 1, 1, 32'h01000108, 1, 32'h00000013, 32'h01000100));
        runVectors("redir_full");
`ifdef FETCH_PERF_EN
        checkOutput("redir_full insn_count", insn_count, 32'd0);
        checkOutput("redir_full stall_count", stall_count, 32'd5);
`endif

        // Reset asserted with a full queue, then a clean restart.
        doReset();
        vecs.delete(); addBackpressure(2);
        vecs.push_back(mkvec(0, 0, 0, 0, 1, 0, BASE + 8, 1, 32'hDEADBEEF, BASE));
        vecs.push_back(mkvec(0, 0, 0, 0, 0, 0, BASE,     1, 32'd0, 32'd0));
        addScenario1();
        runVectors("midrst");

        // Randomized run: delivered stream must follow PC order from reset or the last redirect target.
        doReset();
        exp_issue = BASE; exp_pop = BASE; outstanding = 0; gap = 0; max_gap = 0;
        prev_hold = 1'b0; prev_insn = 0; prev_pc = 0; model_pops = 0; model_stalls = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            rst        = 1'b1;
            r          = $urandom;
            insn_ready = (r[1:0] != 2'b00);
            redirect   = (r[7:3] == 5'd0);
            r          = $urandom;
            redirect_pc = {BASE[31:12], r[11:0]};
            #1;
            if (redirect) begin
                checkOutput("rnd redirect valid", {31'd0, insn_valid}, 32'd0);
                checkOutput("rnd redirect read_en", {31'd0, mem_read_en}, 32'd0);
            end else begin
                if (prev_hold) begin
                    checkOutput("rnd hold valid", {31'd0, insn_valid}, 32'd1);
                    checkOutput("rnd hold insn", insn, prev_insn);
                    checkOutput("rnd hold pc", insn_pc, prev_pc);
                end
                if (mem_read_en) begin
                    checkOutput("rnd issue addr", mem_addr, exp_issue);
                    exp_issue = exp_issue + 4;
                    outstanding++;
                end
                if (insn_valid && insn_ready) begin
                    checkOutput("rnd pop pc", insn_pc, exp_pop);
                    checkOutput("rnd pop insn", insn, mem_word(exp_pop));
                    exp_pop = exp_pop + 4;
                    outstanding--;
                    model_pops++;
                    gap = 0;
                end else if (insn_ready) begin
                    gap++;
                    if (gap > max_gap) max_gap = gap;
                end
                if (insn_valid && !insn_ready) model_stalls++;
                checkOutput("rnd outstanding", {31'd0, (outstanding >= 0 && outstanding <= 2)}, 32'd1);
            end
            prev_hold = insn_valid && !insn_ready && !redirect;
            prev_insn = insn;
            prev_pc   = insn_pc;
            if (redirect) begin
                exp_issue   = redirect_pc & ~32'd3;
                exp_pop     = exp_issue;
                outstanding = 0;
                gap         = 0;
            end
        end
        checkOutput("rnd max ready gap", {31'd0, (max_gap <= 2)}, 32'd1);
        checkOutput("rnd enough pops", {31'd0, (model_pops > 100)}, 32'd1);
        @(posedge clk);
        #1;
        insn_ready = 1'b0;
        redirect   = 1'b0;
`ifdef FETCH_PERF_EN
        checkOutput("rnd insn_count", insn_count, model_pops);
        checkOutput("rnd stall_count", stall_count, model_stalls);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
